// File: rtl/osc_cmd_decoder.sv
// -----------------------------------------------------------------------------
// osc_cmd_decoder
//
// Decodes the MCU-to-FPGA voice command byte stream into oscillator parameter
// writes. It sits between the byte-level link receiver and the oscillator bank.
//
// Frame layout (bytes, multi-byte fields MSB first):
//   0xA5 | osc | cmds | freq[15:8] | freq[7:0] | shape | amp[23:16] |
//   amp[15:8] | amp[7:0] | ENV_LEN x {rate[31:0], duration[31:0]} | chk
// chk is the XOR of every payload byte (sync and chk excluded). A frame whose
// chk matches, whose osc < N_OSC and whose shape <= 3 produces a single-cycle
// wr_en strobe one cycle after the chk byte is taken. Any other frame, and any
// frame that stalls for TIMEOUT cycles, is dropped and counted in err_count.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   in_data       received byte
//   in_valid      in_data valid
//   in_ready      decoder can accept a byte (byte taken when valid && ready)
//   wr_en         one-cycle write strobe to the oscillator bank
//   wr_osc        target oscillator index
//   wr_cmds       command bits (including envelope reset bit)
//   wr_freq       frequency in Hz
//   wr_shape      wave shape encoding
//   wr_amplitude  amplitude (unsigned)
//   wr_env        envelope steps, step 0 in the MSBs, {rate, duration} each
//   err_count     dropped-frame counter, saturates at 255
// wr_* hold the last committed frame between strobes.
// -----------------------------------------------------------------------------
module osc_cmd_decoder #(
  parameter int N_OSC   = 16,
  parameter int WIDTH   = 24,   // amplitude is carried in exactly 3 bytes
  parameter int ENV_LEN = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       wr_en,
  output logic [$clog2(N_OSC)-1:0]   wr_osc,
  output logic [7:0]                 wr_cmds,
  output logic [15:0]                wr_freq,
  output logic [1:0]                 wr_shape,
  output logic [WIDTH-1:0]           wr_amplitude,
  output logic [64*ENV_LEN-1:0]      wr_env,
  output logic [7:0]                 err_count
);

  localparam int         PAYLOAD_BYTES = 8 + 8 * ENV_LEN;
  localparam int         SW            = 8 * PAYLOAD_BYTES;
  localparam int         CNT_W         = $clog2(PAYLOAD_BYTES + 1);
  localparam int         TMO_W         = $clog2(TIMEOUT + 1);
  localparam int         OSC_W         = $clog2(N_OSC);
  localparam logic [7:0] SYNC          = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    COMMIT
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [TMO_W-1:0]        tmo_q;
  logic [7:0]              csum_q;
  logic [7:0]              err_q;
  logic                    in_ready_q;
  logic                    wr_en_q;
  logic [OSC_W-1:0]        wr_osc_q;
  logic [7:0]              wr_cmds_q;
  logic [15:0]             wr_freq_q;
  logic [1:0]              wr_shape_q;
  logic [WIDTH-1:0]        wr_amp_q;
  logic [64*ENV_LEN-1:0]   wr_env_q;

  // Payload shadow: bytes shift in from the LSB end, so once the frame is
  // complete the first payload byte (osc) sits in the top byte.
  logic [SW-1:0]           shadow_q;

  logic                    accept;
  logic                    timeout_hit;
  logic                    frame_ok;
  logic [7:0]              err_inc_d;

  logic [7:0]              sh_osc;
  logic [7:0]              sh_cmds;
  logic [15:0]             sh_freq;
  logic [7:0]              sh_shape;
  logic [23:0]             sh_amp;
  logic [64*ENV_LEN-1:0]   sh_env;

  assign sh_osc   = shadow_q[SW-1  -: 8];
  assign sh_cmds  = shadow_q[SW-9  -: 8];
  assign sh_freq  = shadow_q[SW-17 -: 16];
  assign sh_shape = shadow_q[SW-33 -: 8];
  assign sh_amp   = shadow_q[SW-41 -: 24];
  assign sh_env   = shadow_q[64*ENV_LEN-1:0];

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, so no
    // latch is inferred.
    accept      = in_valid && in_ready_q;
    timeout_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
    frame_ok    = (in_data == csum_q) && (int'(sh_osc) < N_OSC) && (sh_shape <= 8'd3);
    err_inc_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  end

  // NOTE: the shadow is pure datapath and is only ever read after a full
  // frame has overwritten it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == PAYLOAD && accept) begin
      shadow_q <= {shadow_q[SW-9:0], in_data};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmo_q      <= '0;
      csum_q     <= '0;
      err_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_osc_q   <= '0;
      wr_cmds_q  <= '0;
      wr_freq_q  <= '0;
      wr_shape_q <= '0;
      wr_amp_q   <= '0;
      wr_env_q   <= '0;
    end else begin
      // Defaults: strobe low, ready high; only the commit transition overrides.
      wr_en_q    <= 1'b0;
      in_ready_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (accept && in_data == SYNC) begin
            state_q <= PAYLOAD;
            csum_q  <= '0;
            cnt_q   <= '0;
          end
        end

        PAYLOAD: begin
          if (accept) begin
            // A 0xA5 here is ordinary data; there is no resync mid-frame.
            csum_q <= csum_q ^ in_data;
            cnt_q  <= cnt_q + CNT_W'(1);
            tmo_q  <= '0;
            if (cnt_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
              state_q <= CHECK;
            end
          end else if (timeout_hit) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            err_q   <= err_inc_d;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        CHECK: begin
          if (accept) begin
            tmo_q <= '0;
            if (frame_ok) begin
              // Outputs load here so the strobe lands in the COMMIT cycle,
              // one cycle after the chk byte.
              state_q    <= COMMIT;
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
              wr_osc_q   <= sh_osc[OSC_W-1:0];
              wr_cmds_q  <= sh_cmds;
              wr_freq_q  <= sh_freq;
              wr_shape_q <= sh_shape[1:0];
              wr_amp_q   <= sh_amp;
              wr_env_q   <= sh_env;
            end else begin
              state_q <= IDLE;
              err_q   <= err_inc_d;
            end
          end else if (timeout_hit) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            err_q   <= err_inc_d;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        COMMIT: begin
          state_q <= IDLE;
          tmo_q   <= '0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_osc       = wr_osc_q;
  assign wr_cmds      = wr_cmds_q;
  assign wr_freq      = wr_freq_q;
  assign wr_shape     = wr_shape_q;
  assign wr_amplitude = wr_amp_q;
  assign wr_env       = wr_env_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_osc_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_osc_cmd_decoder
//
// Directed bench for osc_cmd_decoder with ENV_LEN=1, N_OSC=16, TIMEOUT=64.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_osc_cmd_decoder;

  logic        clk;
  logic        rstn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_osc;
  logic [7:0]  wr_cmds;
  logic [15:0] wr_freq;
  logic [1:0]  wr_shape;
  logic [23:0] wr_amplitude;
  logic [63:0] wr_env;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  // Strobe monitor: counts wr_en pulses and any two-cycle-high strobe.
  int wr_pulses = 0;
  int b2b_hits  = 0;
  bit wr_en_prev = 1'b0;

  osc_cmd_decoder #(
    .N_OSC  (16),
    .WIDTH  (24),
    .ENV_LEN(1),
    .TIMEOUT(64)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_osc      (wr_osc),
    .wr_cmds     (wr_cmds),
    .wr_freq     (wr_freq),
    .wr_shape    (wr_shape),
    .wr_amplitude(wr_amplitude),
    .wr_env      (wr_env),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_pulses++;
      if (wr_en_prev) b2b_hits++;
    end
    wr_en_prev = wr_en;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one byte and waits (bounded) until the decoder takes it.
  // Returns the number of clock edges spent.
  task automatic send_byte(input logic [7:0] b, output int waited);
    bit acc;
    waited   = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 100);
    if (!acc) check("accept_wait", 64'(waited), 64'd99);
    in_valid = 1'b0;
    in_data  = 8'hA5;  // must be ignored while in_valid is low
  endtask

  // Sends a full frame (optionally without the sync byte); chk is the XOR of
  // the payload, then XORed with flip to corrupt it on purpose.
  task automatic send_frame(input bit skip_sync, input logic [7:0] osc, input logic [7:0] cmds,
                            input logic [15:0] freq, input logic [7:0] shape,
                            input logic [23:0] amp, input logic [31:0] rate,
                            input logic [31:0] dur, input logic [7:0] flip);
    logic [7:0] pl [16];
    logic [7:0] chk;
    int w;
    pl = '{osc, cmds, freq[15:8], freq[7:0], shape, amp[23:16], amp[15:8], amp[7:0],
           rate[31:24], rate[23:16], rate[15:8], rate[7:0],
           dur[31:24], dur[23:16], dur[15:8], dur[7:0]};
    chk = 8'h00;
    foreach (pl[i]) chk ^= pl[i];
    if (!skip_sync) send_byte(8'hA5, w);
    foreach (pl[i]) send_byte(pl[i], w);
    send_byte(chk ^ flip, w);
  endtask

  task automatic expect_wr(input string tag, input logic [3:0] osc, input logic [7:0] cmds,
                           input logic [15:0] freq, input logic [1:0] shape,
                           input logic [23:0] amp, input logic [63:0] env);
    check({tag, "_osc"},   64'(wr_osc),       64'(osc));
    check({tag, "_cmds"},  64'(wr_cmds),      64'(cmds));
    check({tag, "_freq"},  64'(wr_freq),      64'(freq));
    check({tag, "_shape"}, 64'(wr_shape),     64'(shape));
    check({tag, "_amp"},   64'(wr_amplitude), 64'(amp));
    check({tag, "_env"},   wr_env,            env);
  endtask

  initial begin
    int p0;
    int w;
    logic [7:0] e0;

    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // ---- Reset state ------------------------------------------------------
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en",    64'(wr_en),    64'd0);
    check("rst_err",      64'(err_count), 64'd0);
    expect_wr("rst", 4'h0, 8'h00, 16'h0000, 2'd0, 24'h0, 64'h0);
    idle(3);
    rstn = 1'b1;
    check("rel_in_ready_low", 64'(in_ready), 64'd0);
    idle(1);
    check("rel_in_ready_high", 64'(in_ready), 64'd1);

    // ---- 1: good frame, chk = 0x56 ---------------------------------------
    p0 = wr_pulses;
    send_frame(1'b0, 8'h03, 8'h01, 16'd440, 8'h02, 24'h7FFFFF, 32'h00001000, 32'h00000080, 8'h00);
    check("t1_wr_en", 64'(wr_en), 64'd1);
    check("t1_in_ready_commit", 64'(in_ready), 64'd0);
    expect_wr("t1", 4'd3, 8'h01, 16'd440, 2'd2, 24'h7FFFFF, {32'h00001000, 32'h00000080});
    check("t1_err", 64'(err_count), 64'd0);
    idle(1);
    check("t1_wr_en_drop", 64'(wr_en), 64'd0);
    idle(1);
    check("t1_pulses", 64'(wr_pulses - p0), 64'd1);

    // ---- 2: bad chk, then a different good frame --------------------------
    p0 = wr_pulses;
    send_frame(1'b0, 8'h03, 8'h01, 16'd440, 8'h02, 24'h7FFFFF, 32'h00001000, 32'h00000080, 8'h01);
    check("t2_wr_en", 64'(wr_en), 64'd0);
    idle(2);
    check("t2_err", 64'(err_count), 64'd1);
    check("t2_pulses", 64'(wr_pulses - p0), 64'd0);
    expect_wr("t2_hold", 4'd3, 8'h01, 16'd440, 2'd2, 24'h7FFFFF, {32'h00001000, 32'h00000080});
    send_frame(1'b0, 8'h05, 8'h80, 16'h03E8, 8'h01, 24'h123456, 32'hDEADBEEF, 32'h00000001, 8'h00);
    check("t2b_wr_en", 64'(wr_en), 64'd1);
    expect_wr("t2b", 4'd5, 8'h80, 16'h03E8, 2'd1, 24'h123456, {32'hDEADBEEF, 32'h00000001});

    // ---- 3: osc out of range, shape out of range ---------------------------
    idle(2);
    p0 = wr_pulses;
    send_frame(1'b0, 8'h10, 8'h00, 16'd100, 8'h00, 24'h000001, 32'h1, 32'h2, 8'h00);
    idle(2);
    check("t3_osc_err", 64'(err_count), 64'd2);
    send_frame(1'b0, 8'h0F, 8'h00, 16'd100, 8'h04, 24'h000001, 32'h1, 32'h2, 8'h00);
    idle(2);
    check("t3_shape_err", 64'(err_count), 64'd3);
    check("t3_pulses", 64'(wr_pulses - p0), 64'd0);
    expect_wr("t3_hold", 4'd5, 8'h80, 16'h03E8, 2'd1, 24'h123456, {32'hDEADBEEF, 32'h00000001});

    // ---- 4: leading garbage, 0xA5 as payload data ---------------------------
    p0 = wr_pulses;
    send_byte(8'h00, w);
    send_byte(8'hFF, w);
    send_byte(8'h12, w);
    send_frame(1'b0, 8'h0F, 8'hA5, 16'hA5A5, 8'h03, 24'hA50001, 32'h000000A5, 32'hA5000000, 8'h00);
    check("t4_wr_en", 64'(wr_en), 64'd1);
    expect_wr("t4", 4'hF, 8'hA5, 16'hA5A5, 2'd3, 24'hA50001, {32'h000000A5, 32'hA5000000});
    idle(2);
    check("t4_pulses", 64'(wr_pulses - p0), 64'd1);
    check("t4_err", 64'(err_count), 64'd3);

    // ---- 5: stall after 5 payload bytes -> timeout --------------------------
    p0 = wr_pulses;
    send_byte(8'hA5, w);
    send_byte(8'h01, w);
    send_byte(8'h02, w);
    send_byte(8'h03, w);
    send_byte(8'h04, w);
    send_byte(8'h00, w);
    idle(60);
    check("t5_err_before_timeout", 64'(err_count), 64'd3);
    idle(6);
    check("t5_err_after_timeout", 64'(err_count), 64'd4);
    check("t5_pulses", 64'(wr_pulses - p0), 64'd0);
    send_frame(1'b0, 8'h07, 8'h02, 16'd1234, 8'h00, 24'h0000FF, 32'h11223344, 32'h55667788, 8'h00);
    check("t5_wr_en", 64'(wr_en), 64'd1);
    expect_wr("t5", 4'd7, 8'h02, 16'd1234, 2'd0, 24'h0000FF, {32'h11223344, 32'h55667788});

    // ---- 6a: in_valid held through COMMIT -----------------------------------
    check("t6_in_ready_commit", 64'(in_ready), 64'd0);
    send_byte(8'hA5, w);
    check("t6_held_wait", 64'(w), 64'd2);
    send_frame(1'b1, 8'h01, 8'h40, 16'd50, 8'h02, 24'h800000, 32'h0000FFFF, 32'hFFFF0000, 8'h00);
    check("t6_wr_en", 64'(wr_en), 64'd1);
    expect_wr("t6", 4'd1, 8'h40, 16'd50, 2'd2, 24'h800000, {32'h0000FFFF, 32'hFFFF0000});
    idle(2);

    // ---- 6b: reset mid-payload ---------------------------------------------
    p0 = wr_pulses;
    e0 = err_count;
    check("t6_err_pre_reset", 64'(e0), 64'd4);
    send_byte(8'hA5, w);
    send_byte(8'h02, w);
    send_byte(8'h03, w);
    rstn = 1'b0;
    #1;
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    check("t6_rst_err", 64'(err_count), 64'd0);
    expect_wr("t6_rst", 4'h0, 8'h00, 16'h0000, 2'd0, 24'h0, 64'h0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    check("t6_rel_in_ready", 64'(in_ready), 64'd1);
    idle(80);
    check("t6_no_err_after_reset", 64'(err_count), 64'd0);
    check("t6_no_pulse_after_reset", 64'(wr_pulses - p0), 64'd0);

    // ---- 6c: 300 bad frames -> saturation -----------------------------------
    for (int i = 1; i <= 300; i++) begin
      send_frame(1'b0, 8'h02, 8'h00, 16'd10, 8'h01, 24'h000010, 32'h5, 32'h6, 8'h80);
      if (i == 100) begin
        idle(1);
        check("t6_err_100", 64'(err_count), 64'd100);
      end
    end
    idle(2);
    check("t6_err_sat", 64'(err_count), 64'd255);
    check("t6_sat_no_pulse", 64'(wr_pulses - p0), 64'd0);
    check("no_back_to_back_wr_en", 64'(b2b_hits), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
